buzzer_arbiter: RTL

Fixed-priority scheduler that shares the single buzzer output (BZ1) between three requesters: key-click (src0), notify beep (src1) and alarm (src2). Requesters issue one-cycle pulses; the arbiter queues them, grants one at a time, enforces per-source play durations and a silent gap between grants, and drives enable and tone-select into the downstream tone generator. It sits between the timer/button FSMs and the tone generator in the top level.

---
 rtl/buzzer_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer arbiter: queues one-cycle requests, plays one source at a time with a gap.
// Optional build macro BUZZ_ARB_REQUEUE_EN re-queues a timed source that is preempted.
module buzzer_arbiter #(
  parameter int unsigned IN_CLK  = 50_000_000,
  parameter int unsigned DUR0_MS = 50,
  parameter int unsigned DUR1_MS = 200,
  parameter int unsigned GAP_MS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       stop,
  output logic [2:0] grant,
  output logic       tone_en,
  output logic [1:0] tone_sel,
  output logic       busy,
  output logic       dropped
);

  localparam int unsigned Tick    = IN_CLK / 1000;
  localparam logic [31:0] Dur0Cyc = DUR0_MS * Tick;
  localparam logic [31:0] Dur1Cyc = DUR1_MS * Tick;
  localparam logic [31:0] GapCyc  = GAP_MS * Tick;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cur_q, cur_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  pend_q, pend_d;
  logic        dropped_q, dropped_d;

  logic [2:0]  clr;
  logic [2:0]  requeue;
  logic        higher;
  logic        timeout;

  // A pending request from a strictly higher-priority source than the one playing.
  always_comb begin
    unique case (cur_q)
      2'd0:    higher = pend_q[2] | pend_q[1];
      2'd1:    higher = pend_q[2];
      default: higher = 1'b0;
    endcase
  end

  // src2 is untimed; only src0/src1 expire on the counter.
  assign timeout = (cur_q != 2'd2) && (cnt_q == 32'd1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    clr     = 3'b000;
    requeue = 3'b000;

    unique case (state_q)
      StIdle: begin
        if (pend_q != 3'b000) begin
          if (pend_q[2])      cur_d = 2'd2;
          else if (pend_q[1]) cur_d = 2'd1;
          else                cur_d = 2'd0;
          clr = 3'b001 << cur_d;
          unique case (cur_d)
            2'd0:    cnt_d = Dur0Cyc;
            2'd1:    cnt_d = Dur1Cyc;
            default: cnt_d = 32'd0;
          endcase
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (cur_q != 2'd2) cnt_d = cnt_q - 32'd1;
        if (stop || timeout || higher) begin
          state_d = StGap;
          cnt_d   = GapCyc;
`ifdef BUZZ_ARB_REQUEUE_EN
          // Only a pure preemption replays; stop or a finished play does not.
          if (higher && !stop && !timeout) requeue = 3'b001 << cur_q;
`endif
        end
      end
      StGap: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Set beats clear, so a request arriving as its source is selected is kept.
    pend_d    = (pend_q & ~clr) | req | requeue;
    dropped_d = |(req & pend_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_q     <= 2'd0;
      cnt_q     <= 32'd0;
      pend_q    <= 3'b000;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      dropped_q <= dropped_d;
    end
  end

  assign grant    = (state_q == StPlay) ? (3'b001 << cur_q) : 3'b000;
  assign tone_en  = (state_q == StPlay);
  assign tone_sel = (state_q == StPlay) ? cur_q : 2'd0;
  assign busy     = (state_q != StIdle);
  assign dropped  = dropped_q;

endmodule
